seq_writeback_regfile: RTL and testbench

Writeback stage and architectural register file for the SEQ Y86-64 processor. Receives the executed instruction (icode, rA, rB, cnd) with its ALU result valE and memory result valM, then derives the destination registers dstE/dstM and commits them on the clock edge. Serves the decode stage's two combinational read ports, srcA and srcB, and tracks processor status (RUN/HALT/ERR) and retired-instruction count.

---
 rtl/seq_writeback_regfile_if.sv | 39 +++
 rtl/seq_writeback_regfile.sv | 161 ++++++++++++++++
 tb/tb_seq_writeback_regfile.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_writeback_regfile_if.sv
// rtl/seq_writeback_regfile_if.sv - writeback/regfile bus bundle
//
// Purpose: groups the writeback inputs, the decode read ports and the
// status/trace outputs of seq_writeback_regfile into one bundle.
// Ports (master = driver side, slave = regfile side):
//   wb_en, icode, rA, rB, cnd, valE, valM : executed instruction to commit
//   srcA, srcB -> rdA, rdB                : combinational register reads
//   dstE, dstM                            : decoded destinations (trace)
//   halted, err, retired                  : processor status
interface seq_writeback_regfile_if #(
  parameter int WIDTH = 64
);
  logic             wb_en;
  logic [3:0]       icode;
  logic [3:0]       rA;
  logic [3:0]       rB;
  logic             cnd;
  logic [WIDTH-1:0] valE;
  logic [WIDTH-1:0] valM;
  logic [3:0]       srcA;
  logic [3:0]       srcB;
  logic [WIDTH-1:0] rdA;
  logic [WIDTH-1:0] rdB;
  logic [3:0]       dstE;
  logic [3:0]       dstM;
  logic             halted;
  logic             err;
  logic [63:0]      retired;

  modport master (
    output wb_en, icode, rA, rB, cnd, valE, valM, srcA, srcB,
    input  rdA, rdB, dstE, dstM, halted, err, retired
  );

  modport slave (
    input  wb_en, icode, rA, rB, cnd, valE, valM, srcA, srcB,
    output rdA, rdB, dstE, dstM, halted, err, retired
  );
endinterface

// File: rtl/seq_writeback_regfile.sv
// rtl/seq_writeback_regfile.sv - SEQ Y86-64 writeback stage and register file
//
// Purpose: decodes dstE/dstM from the executed instruction, commits valE/valM
// into a 15-entry register file, serves two combinational read ports, and
// tracks processor status (RUN/HALT/ERR) plus the retired-instruction count.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   wb   : seq_writeback_regfile_if.slave (see interface file)
module seq_writeback_regfile #(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RSP   = 4'h4
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_writeback_regfile_if.slave wb
);

  localparam int         NREGS   = 15;
  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;
  localparam logic [3:0] I_LASTOK = 4'hB;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } status_e;

  status_e          status_q, status_d;
  logic [63:0]      retired_q, retired_d;
  logic [WIDTH-1:0] regs_q [NREGS];

  logic [3:0]       dst_e;
  logic [3:0]       dst_m;
  logic             retire_en;

  // ---------------------------------------------------------------------------
  // Destination decode (independent of wb_en)
  // ---------------------------------------------------------------------------
  always_comb begin
    dst_e = RNONE;
    unique case (wb.icode)
      I_CMOV:                       dst_e = wb.cnd ? wb.rB : RNONE;
      I_IRMOV, I_OPQ:               dst_e = wb.rB;
      I_CALL, I_RET, I_PUSH, I_POP: dst_e = RSP;
      default:                      dst_e = RNONE;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    unique case (wb.icode)
      I_MRMOV, I_POP: dst_m = wb.rA;
      default:        dst_m = RNONE;
    endcase
  end

  assign wb.dstE = dst_e;
  assign wb.dstM = dst_m;

  // ---------------------------------------------------------------------------
  // Status FSM and retire decision
  // ---------------------------------------------------------------------------
  always_comb begin
    status_d  = status_q;
    retire_en = 1'b0;
    unique case (status_q)
      ST_RUN: begin
        if (wb.wb_en) begin
          if (wb.icode > I_LASTOK) begin
            // Invalid instruction: trap without retiring it.
            status_d = ST_ERR;
          end else begin
            // Halt retires like any other instruction; its dsts are RNONE,
            // so it performs no register write.
            retire_en = 1'b1;
            if (wb.icode == I_HALT) begin
              status_d = ST_HALT;
            end
          end
        end
      end
      ST_HALT: status_d = ST_HALT;
      ST_ERR:  status_d = ST_ERR;
      default: status_d = ST_ERR;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (retire_en) begin
      retired_d = retired_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= ST_RUN;
      retired_q <= '0;
    end else begin
      status_q  <= status_d;
      retired_q <= retired_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. The M port wins when both ports target the same register
  // (popq %rsp loads the popped value, not the incremented stack pointer).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= WIDTH'(i);
      end
    end else if (retire_en) begin
      for (int i = 0; i < NREGS; i++) begin
        if (dst_m == 4'(i)) begin
          regs_q[i] <= wb.valM;
        end else if (dst_e == 4'(i)) begin
          regs_q[i] <= wb.valE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: no bypass, RNONE reads as zero
  // ---------------------------------------------------------------------------
  always_comb begin
    wb.rdA = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (wb.srcA == 4'(i)) begin
        wb.rdA = regs_q[i];
      end
    end
  end

  always_comb begin
    wb.rdB = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (wb.srcB == 4'(i)) begin
        wb.rdB = regs_q[i];
      end
    end
  end

  assign wb.halted  = (status_q == ST_HALT);
  assign wb.err     = (status_q == ST_ERR);
  assign wb.retired = retired_q;

endmodule

// File: tb/tb_seq_writeback_regfile.sv
// tb/tb_seq_writeback_regfile.sv - bench for seq_writeback_regfile
module tb_seq_writeback_regfile;

  logic clk;
  logic rst;

  seq_writeback_regfile_if #(.WIDTH(64)) wbif ();

  seq_writeback_regfile #(.WIDTH(64), .RSP(4'h4)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural state as plain arrays and integers.
  logic [63:0] m_regs [15];
  int          m_status;   // 0 run, 1 halt, 2 err
  logic [63:0] m_ret;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (ic == 4'h2) return c ? rb : 4'hF;
    if (ic == 4'h3 || ic == 4'h6) return rb;
    if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    if (ic == 4'h5 || ic == 4'hB) return ra;
    return 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] s);
    return (s == 4'hF) ? 64'd0 : m_regs[s];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = 64'(i);
    m_status = 0;
    m_ret    = 64'd0;
  endtask

  // One clock: drive, check combinational outputs against the pre-edge model,
  // advance the model across the edge, then check registered status.
  task automatic do_cycle(input logic r, input logic we, input logic [3:0] ic,
                          input logic [3:0] ra, input logic [3:0] rb, input logic c,
                          input logic [63:0] ve, input logic [63:0] vm);
    logic [3:0] de, dm;
    rst        = r;
    wbif.wb_en = we;
    wbif.icode = ic;
    wbif.rA    = ra;
    wbif.rB    = rb;
    wbif.cnd   = c;
    wbif.valE  = ve;
    wbif.valM  = vm;
    #1;
    de = m_dst_e(ic, rb, c);
    dm = m_dst_m(ic, ra);
    check_val("rdA", wbif.rdA, m_read(wbif.srcA));
    check_val("rdB", wbif.rdB, m_read(wbif.srcB));
    check_val("dstE", 64'(wbif.dstE), 64'(de));
    check_val("dstM", 64'(wbif.dstM), 64'(dm));
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (we && m_status == 0) begin
      if (ic > 4'hB) begin
        m_status = 2;
      end else begin
        m_ret = m_ret + 64'd1;
        if (ic == 4'h0) m_status = 1;
        if (de != 4'hF) m_regs[de] = ve;
        if (dm != 4'hF) m_regs[dm] = vm;   // applied last, so M wins
      end
    end
    #1;
    check_val("halted", 64'(wbif.halted), 64'(m_status == 1));
    check_val("err", 64'(wbif.err), 64'(m_status == 2));
    check_val("retired", wbif.retired, m_ret);
    @(negedge clk);
  endtask

  task automatic peek(input logic [3:0] sa, input logic [3:0] sb);
    wbif.wb_en = 1'b0;
    wbif.srcA  = sa;
    wbif.srcB  = sb;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    wbif.wb_en = 1'b0;
    wbif.icode = 4'h1;
    wbif.rA    = 4'hF;
    wbif.rB    = 4'hF;
    wbif.cnd   = 1'b0;
    wbif.valE  = '0;
    wbif.valM  = '0;
    wbif.srcA  = 4'h0;
    wbif.srcB  = 4'h0;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    peek(4'h3, 4'hE);
    check_val("rst_rdA3", wbif.rdA, 64'd3);
    check_val("rst_rdB14", wbif.rdB, 64'd14);
    peek(4'hF, 4'hE);
    check_val("rst_rdA_none", wbif.rdA, 64'd0);
    check_val("rst_halted", 64'(wbif.halted), 64'd0);
    check_val("rst_err", 64'(wbif.err), 64'd0);
    check_val("rst_retired", wbif.retired, 64'd0);

    // OPq into r2: no bypass in the same cycle
    peek(4'h0, 4'h2);
    check_val("opq_same_cycle", wbif.rdB, 64'd2);
    do_cycle(1'b0, 1'b1, 4'h6, 4'hF, 4'h2, 1'b0, 64'h55, 64'h0);
    peek(4'h0, 4'h2);
    check_val("opq_r2", wbif.rdB, 64'h55);
    check_val("opq_retired", wbif.retired, 64'd1);

    // cmovXX into r7
    do_cycle(1'b0, 1'b1, 4'h2, 4'h3, 4'h7, 1'b0, 64'h99, 64'h0);
    peek(4'h7, 4'h0);
    check_val("cmov_nc_r7", wbif.rdA, 64'd7);
    do_cycle(1'b0, 1'b1, 4'h2, 4'h3, 4'h7, 1'b1, 64'h99, 64'h0);
    peek(4'h7, 4'h0);
    check_val("cmov_c_r7", wbif.rdA, 64'h99);

    // popq %rsp: M port wins
    do_cycle(1'b0, 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hABC);
    peek(4'h4, 4'h4);
    check_val("popq_r4", wbif.rdA, 64'hABC);
    check_val("popq_retired", wbif.retired, 64'd4);

    // Halt and frozen state afterwards
    do_cycle(1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    check_val("halt_halted", 64'(wbif.halted), 64'd1);
    do_cycle(1'b0, 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'hFF, 64'h0);
    peek(4'h1, 4'h0);
    check_val("halt_r1", wbif.rdA, 64'd1);
    check_val("halt_retired", wbif.retired, 64'd5);
    do_cycle(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    peek(4'h1, 4'h7);
    check_val("rst_halted_clr", 64'(wbif.halted), 64'd0);
    check_val("rst_r1", wbif.rdA, 64'd1);
    check_val("rst_r7", wbif.rdB, 64'd7);

    // Invalid instruction
    do_cycle(1'b0, 1'b1, 4'hC, 4'h3, 4'h3, 1'b1, 64'h123, 64'h456);
    peek(4'h3, 4'h0);
    check_val("inv_err", 64'(wbif.err), 64'd1);
    check_val("inv_retired", wbif.retired, 64'd0);
    check_val("inv_r3", wbif.rdA, 64'd3);

    // rst beats wb_en in the same cycle
    do_cycle(1'b1, 1'b1, 4'h5, 4'h5, 4'hF, 1'b0, 64'h0, 64'h77);
    peek(4'h5, 4'h0);
    check_val("rstwb_r5", wbif.rdA, 64'd5);
    check_val("rstwb_err", 64'(wbif.err), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  ic;
      logic        r;
      int          sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 3)      ic = 4'h0;
      else if (sel < 6) ic = 4'(($urandom_range(12, 15)));
      else              ic = 4'(($urandom_range(1, 11)));
      r = ($urandom_range(0, 39) == 0) || (m_status != 0 && $urandom_range(0, 3) == 0);
      wbif.srcA = 4'($urandom_range(0, 15));
      wbif.srcB = 4'($urandom_range(0, 15));
      do_cycle(r, 1'($urandom_range(0, 3) != 0), ic,
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)),
               {$urandom, $urandom}, {$urandom, $urandom});
    end

    // Final sweep of the whole register file
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), 4'(15 - i));
      check_val("sweep_rdA", wbif.rdA, m_read(4'(i)));
      check_val("sweep_rdB", wbif.rdB, m_read(4'(15 - i)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
